// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO drains into a bit-serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_buffered #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 9600,
  parameter int FifoDepth    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_valid,
  input  logic [7:0]                   tx_data,
  output logic                         tx_ready,
  output logic                         txd,
  output logic                         txd_busy,
  output logic [$clog2(FifoDepth):0]   fifo_count
);

  localparam int DATA_W = 8;
  localparam int DIV    = ClkFrequency / Baud;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FifoDepth);
  localparam int FC_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [FC_W-1:0]  FULL_CNT = FC_W'(FifoDepth);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction
`endif

  logic [DATA_W-1:0] mem [FifoDepth];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FC_W-1:0]   count_q;
  logic              push, pop, fifo_empty, bit_end;
  logic [DATA_W-1:0] head;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign tx_ready   = (count_q < FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr];
  assign bit_end    = (cnt_q == CNT_LAST);

  assign txd        = txd_q;
  assign fifo_count = count_q;
  assign txd_busy   = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(head);
`endif
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            // Next bit moves into shift_q[0] for the following period
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(head);
`endif
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      wr_ptr    <= wr_ptr + PTR_W'(push);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      count_q   <= count_q + FC_W'(push) - FC_W'(pop);
    end
  end

  // Data storage carries no reset; control above decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

endmodule
